// File: rtl/wb_sequencer.sv
// Writeback sequencer: drives the writeback-mux select and register-unit write enable, and runs the data-memory handshake with a timeout watchdog.
// Optional stall performance counter (StallCnt output) is enabled by defining WB_PERF_CNT_EN.
module wb_sequencer #(
    parameter int unsigned DM_TIMEOUT = 15
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       InstValid,
    input  logic       RUWr,
    input  logic [1:0] RUDataWrSrcIn,
    input  logic [4:0] Rd,
    input  logic       DMRd,
    input  logic       DMWr,
    input  logic       DMAck,
    output logic       DMReq,
    output logic       DMWe,
    output logic [1:0] RUDataWrSrc,
    output logic       RUWrEn,
    output logic [4:0] RdOut,
    output logic       Stall,
    output logic       DMErr
`ifdef WB_PERF_CNT_EN
    ,
    output logic [31:0] StallCnt
`endif
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        MEM_WAIT = 2'd1,
        ERR      = 2'd2
    } state_t;

    localparam logic [7:0] TIMEOUT_LAST = 8'(DM_TIMEOUT - 1);
    localparam logic [1:0] SRC_DATARD  = 2'b01;

    state_t     state_r, state_s;
    logic [4:0] rd_r, rd_s;
    logic       ruwr_r, ruwr_s;
    logic       load_r, load_s;
    logic       dmreq_r, dmreq_s;
    logic       dmwe_r, dmwe_s;
    logic       dmerr_r, dmerr_s;
    logic [7:0] cnt_r, cnt_s;

    logic [1:0] wb_src_s;
    logic [4:0] rd_out_s;
    logic       ru_wr_en_s;
    logic       stall_s;

    // Next-state and output decode for the writeback/memory sequencer
    always_comb begin
        state_s    = state_r;
        rd_s       = rd_r;
        ruwr_s     = ruwr_r;
        load_s     = load_r;
        dmreq_s    = dmreq_r;
        dmwe_s     = dmwe_r;
        dmerr_s    = dmerr_r;
        cnt_s      = cnt_r;
        wb_src_s   = RUDataWrSrcIn;
        rd_out_s   = 5'd0;
        ru_wr_en_s = 1'b0;
        stall_s    = 1'b0;
        case (state_r)
            IDLE: begin
                if (InstValid) begin
                    rd_out_s = Rd;
                    if (DMRd || DMWr) begin
                        // DMRd wins when both kinds are flagged
                        rd_s    = Rd;
                        ruwr_s  = RUWr;
                        load_s  = DMRd;
                        dmreq_s = 1'b1;
                        dmwe_s  = !DMRd;
                        cnt_s   = 8'd0;
                        stall_s = 1'b1;
                        state_s = MEM_WAIT;
                    end else begin
                        ru_wr_en_s = RUWr && (Rd != 5'd0);
                    end
                end else begin
                    rd_out_s = 5'd0;
                end
            end
            MEM_WAIT: begin
                rd_out_s = rd_r;
                wb_src_s = SRC_DATARD;
                if (DMAck) begin
                    ru_wr_en_s = ruwr_r && (rd_r != 5'd0) && load_r;
                    dmreq_s    = 1'b0;
                    dmwe_s     = 1'b0;
                    state_s    = IDLE;
                end else begin
                    stall_s = 1'b1;
                    if (cnt_r == TIMEOUT_LAST) begin
                        dmreq_s = 1'b0;
                        dmwe_s  = 1'b0;
                        dmerr_s = 1'b1;
                        state_s = ERR;
                    end else begin
                        cnt_s = cnt_r + 8'd1;
                    end
                end
            end
            ERR: begin
                stall_s = 1'b1;
                dmreq_s = 1'b0;
                dmwe_s  = 1'b0;
                dmerr_s = 1'b1;
            end
            default: begin
                stall_s = 1'b1;
                dmreq_s = 1'b0;
                dmwe_s  = 1'b0;
                state_s = IDLE;
            end
        endcase
    end

    // State and latched-transaction registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= IDLE;
            rd_r    <= 5'd0;
            ruwr_r  <= 1'b0;
            load_r  <= 1'b0;
            dmreq_r <= 1'b0;
            dmwe_r  <= 1'b0;
            dmerr_r <= 1'b0;
            cnt_r   <= 8'd0;
        end else begin
            state_r <= state_s;
            rd_r    <= rd_s;
            ruwr_r  <= ruwr_s;
            load_r  <= load_s;
            dmreq_r <= dmreq_s;
            dmwe_r  <= dmwe_s;
            dmerr_r <= dmerr_s;
            cnt_r   <= cnt_s;
        end
    end

    // A reset cycle never commits a register write, even if an ack coincides
    assign RUWrEn      = ru_wr_en_s && !rst;
    assign RUDataWrSrc = wb_src_s;
    assign RdOut       = rd_out_s;
    assign Stall       = stall_s;
    assign DMReq       = dmreq_r;
    assign DMWe        = dmwe_r;
    assign DMErr       = dmerr_r;

`ifdef WB_PERF_CNT_EN
    logic [31:0] stall_cnt_r;

    // Saturating count of stalled cycles
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt_r <= 32'd0;
        end else if (stall_s && (stall_cnt_r != 32'hFFFF_FFFF)) begin
            stall_cnt_r <= stall_cnt_r + 32'd1;
        end else begin
            stall_cnt_r <= stall_cnt_r;
        end
    end

    assign StallCnt = stall_cnt_r;
`endif

endmodule
